// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Latency: grant to PSEL 1 cycle, 3 cycles minimum per transfer, ACCESS bounded by TMO_CYC.
// Backpressure: requesters hold req_valid until req_ready; req_valid is ignored while busy.
module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int ABITS   = 10,
    parameter int DBITS   = 16,
    parameter int TMO_CYC = 255,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               apb_clk,
    input  logic               apb_rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*ABITS-1:0] req_addr,
    input  logic [NREQ*DBITS-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DBITS-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               apb_sel,
    output logic               apb_enable,
    output logic               apb_write,
    output logic [ABITS-1:0]   apb_addr,
    output logic [DBITS-1:0]   apb_wdata,
    input  logic [DBITS-1:0]   apb_rdata,
    input  logic               apb_ready,
    input  logic               apb_slverr,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic [15:0]        err_cnt
);
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
    localparam logic [GW-1:0] PTR_RST  = GW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, win;
    logic            any_req;
    logic [NREQ-1:0] win_oh, gnt_oh;
    logic [TW-1:0]   tmo_q;
    logic            tmo_hit, access_done, done_err;

    // Scan ptr+1 .. ptr; iterating from the far end leaves the nearest requester as winner.
    always_comb begin : arbitrate
        int idx;
        win     = ptr_q;
        any_req = 1'b0;
        idx     = 0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (req_valid[idx]) begin
                win     = GW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh           = '0;
        win_oh[win]      = 1'b1;
        gnt_oh           = '0;
        gnt_oh[grant_id] = 1'b1;
    end

    assign tmo_hit     = (TMO_CYC != 0) && (tmo_q == TMO_LAST);
    assign access_done = (state_q == ACCESS) && (apb_ready || tmo_hit);
    assign done_err    = !apb_ready || apb_slverr;

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with the phase.
    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            ptr_q      <= PTR_RST;
            tmo_q      <= '0;
            grant_id   <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
            busy       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            apb_sel    <= (state_d != IDLE);
            apb_enable <= (state_d == ACCESS);
            busy       <= (state_d != IDLE);
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;

            if (state_q == IDLE && any_req) begin
                ptr_q     <= win;
                grant_id  <= win;
                req_ready <= win_oh;
                apb_write <= req_write[win];
                apb_addr  <= req_addr[win*ABITS +: ABITS];
                apb_wdata <= req_wdata[win*DBITS +: DBITS];
            end

            if (state_q == ACCESS && !access_done) tmo_q <= tmo_q + 1'b1;
            else                                   tmo_q <= '0;

            if (access_done) begin
                rsp_valid <= gnt_oh;
                rsp_err   <= done_err;
                rsp_rdata <= (apb_ready && !apb_write) ? apb_rdata : '0;
                if (done_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter against a transaction-level round-robin/APB model.
module tb_apb_rr_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 8;

    logic          apb_clk, apb_rst_n;
    logic [3:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [39:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [15:0]   rsp_rdata, apb_wdata, apb_rdata, err_cnt;
    logic          rsp_err, apb_sel, apb_enable, apb_write, apb_ready, apb_slverr, busy;
    logic [9:0]    apb_addr;
    logic [1:0]    grant_id;

    apb_rr_arbiter #(.NREQ(NR), .ABITS(10), .DBITS(16), .TMO_CYC(TMO)) dut (
        .apb_clk(apb_clk), .apb_rst_n(apb_rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .apb_sel(apb_sel),
        .apb_enable(apb_enable), .apb_write(apb_write), .apb_addr(apb_addr),
        .apb_wdata(apb_wdata), .apb_rdata(apb_rdata), .apb_ready(apb_ready),
        .apb_slverr(apb_slverr), .grant_id(grant_id), .busy(busy), .err_cnt(err_cnt)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending requests with their commands, last grant, error count.
    logic [3:0]  pending;
    logic        cmd_write [NR];
    logic [9:0]  cmd_addr  [NR];
    logic [15:0] cmd_wdata [NR];
    int          mptr;
    logic [15:0] merr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pending[i];
            req_write[i]            = cmd_write[i];
            req_addr[i*10 +: 10]    = cmd_addr[i];
            req_wdata[i*16 +: 16]   = cmd_wdata[i];
        end
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [9:0] a, input logic [15:0] d);
        cmd_write[i] = wr;
        cmd_addr[i]  = a;
        cmd_wdata[i] = d;
        pending[i]   = 1'b1;
    endtask

    function automatic int pick();
        for (int k = 1; k <= NR; k++)
            if (pending[(mptr + k) % NR]) return (mptr + k) % NR;
        return 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_sel"}, apb_sel, 0);
        check({tag, "_en"}, apb_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp"}, rsp_valid, 0);
        check({tag, "_rdy"}, req_ready, 0);
    endtask

    // Entered and left at an IDLE cycle; wt = ACCESS cycles before apb_ready.
    task automatic xfer(input int wt, input logic serr, input logic [15:0] rd,
                        input bit hold, output int g);
        int   w;
        logic tmo, exp_err;
        logic [3:0] oh;
        w  = pick();
        mptr = w;
        oh = 4'b0001 << w;
        apb_ready  = 1'($urandom);
        apb_slverr = 1'($urandom);
        apb_rdata  = 16'($urandom);
        drive();
        step();
        g = int'(grant_id);
        check("setup_sel", apb_sel, 1);
        check("setup_en", apb_enable, 0);
        check("setup_rdy", req_ready, oh);
        check("setup_gid", grant_id, w);
        check("setup_busy", busy, 1);
        check("setup_rsp", rsp_valid, 0);
        check("setup_addr", apb_addr, cmd_addr[w]);
        check("setup_wr", apb_write, cmd_write[w]);
        check("setup_wd", apb_wdata, cmd_wdata[w]);
        if (!hold) pending[w] = 1'b0;
        drive();
        step();
        for (int a = 0; a <= TMO; a++) begin
            check("acc_sel", apb_sel, 1);
            check("acc_en", apb_enable, 1);
            check("acc_rdy", req_ready, 0);
            check("acc_rsp", rsp_valid, 0);
            check("acc_addr", apb_addr, cmd_addr[w]);
            if (a == wt) begin
                apb_ready  = 1'b1;
                apb_slverr = serr;
                apb_rdata  = rd;
                step();
                break;
            end
            apb_ready  = 1'b0;
            apb_slverr = 1'($urandom);
            apb_rdata  = 16'($urandom);
            step();
            if (a == TMO - 1) break;
        end
        tmo     = (wt >= TMO);
        exp_err = tmo | serr;
        if (exp_err && merr != 16'hFFFF) merr = merr + 16'd1;
        check("cmp_rsp", rsp_valid, oh);
        check("cmp_err", rsp_err, exp_err);
        check("cmp_rdata", rsp_rdata, (tmo || cmd_write[w]) ? 16'h0 : rd);
        check("cmp_errcnt", err_cnt, merr);
        check("cmp_sel", apb_sel, 0);
        check("cmp_en", apb_enable, 0);
        check("cmp_busy", busy, 0);
        check("cmp_addr_hold", apb_addr, cmd_addr[w]);
        apb_ready  = 1'b0;
        apb_slverr = 1'b0;
    endtask

    initial begin
        int g;
        logic [3:0] mask;
        pending = '0;
        for (int i = 0; i < NR; i++) begin
            cmd_write[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
        end
        mptr = NR - 1;
        merr = '0;
        apb_rst_n = 1'b0;
        apb_ready = 1'b0; apb_slverr = 1'b0; apb_rdata = '0;
        drive();
        step();
        step();
        check_idle("rst");
        check("rst_gid", grant_id, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_addr", apb_addr, 0);
        apb_rst_n = 1'b1;
        step();

        // All requesters held high: strict rotation from requester 0.
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b1, 10'(16 * i), 16'(i));
        for (int k = 0; k < NR; k++) begin
            xfer(0, 1'b0, 16'h0, 1'b1, g);
            check("rr_all", g, k);
        end
        pending = 4'b0101;
        xfer(1, 1'b0, 16'h0, 1'b0, g);
        check("rr_02_a", g, 0);
        xfer(0, 1'b0, 16'h0, 1'b0, g);
        check("rr_02_b", g, 2);

        set_cmd(0, 1'b1, 10'h055, 16'hA5A5);
        xfer(0, 1'b0, 16'h0, 1'b0, g);
        set_cmd(1, 1'b0, 10'h3FF, 16'h0);
        xfer(5, 1'b0, 16'h1234, 1'b0, g);
        set_cmd(2, 1'b0, 10'h123, 16'h0);
        xfer(100, 1'b0, 16'hBEEF, 1'b0, g);
        check("tmo_errcnt", err_cnt, 1);
        set_cmd(3, 1'b0, 10'h0AA, 16'h0);
        xfer(2, 1'b0, 16'h5A5A, 1'b0, g);
        set_cmd(0, 1'b1, 10'h011, 16'h7777);
        xfer(1, 1'b1, 16'h0, 1'b0, g);
        check("slverr_errcnt", err_cnt, 2);

        force dut.err_cnt = 16'hFFFF;
        #1;
        release dut.err_cnt;
        merr = 16'hFFFF;
        set_cmd(1, 1'b1, 10'h022, 16'h1111);
        xfer(0, 1'b1, 16'h0, 1'b0, g);
        set_cmd(2, 1'b0, 10'h033, 16'h0);
        xfer(20, 1'b0, 16'h0, 1'b0, g);

        // Reset in the middle of ACCESS.
        set_cmd(1, 1'b0, 10'h044, 16'h0);
        mptr = 1;
        drive();
        step();
        pending = '0;
        drive();
        step();
        apb_ready = 1'b0;
        step();
        check("pre_rst_busy", busy, 1);
        apb_rst_n = 1'b0;
        #1;
        check_idle("arst");
        check("arst_errcnt", err_cnt, 0);
        check("arst_gid", grant_id, 0);
        step();
        #2;
        apb_rst_n = 1'b1;
        mptr = NR - 1;
        merr = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("post_rst");
        end
        set_cmd(0, 1'b1, 10'h100, 16'h0F0F);
        set_cmd(2, 1'b1, 10'h200, 16'hF0F0);
        xfer(0, 1'b0, 16'h0, 1'b0, g);
        check("post_rst_grant", g, 0);
        xfer(0, 1'b0, 16'h0, 1'b0, g);

        for (int n = 0; n < 150; n++) begin
            if (pending == 4'b0 && ($urandom % 4) == 0) begin
                drive();
                step();
                check_idle("gap");
            end
            mask = 4'($urandom);
            for (int i = 0; i < NR; i++)
                if (mask[i] && !pending[i])
                    set_cmd(i, 1'($urandom), 10'($urandom), 16'($urandom));
            if (pending == 4'b0)
                set_cmd(int'($urandom % NR), 1'($urandom), 10'($urandom), 16'($urandom));
            xfer(($urandom % 4 == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 3)),
                 1'(($urandom % 4) == 0), 16'($urandom), 1'b0, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
